// File: rtl/countdown_scheduler.sv
// countdown_scheduler
// Lends one shared CW-bit down-counter to NREQ timing clients in round-robin
// order. The granted client's delay is loaded, counted down to zero, and
// answered with a one-cycle done pulse. A withdrawn request or a global abort
// cancels the service silently (no done pulse).
module countdown_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   req_delay,
    input  logic                 abort,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [CW-1:0]        count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // The pointer starts at the top index so that requester 0 wins the very
    // first arbitration after reset.
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [CW-1:0]     count_q, count_d;
    logic [IW-1:0]     last_q, last_d;

    // Per-requester view of the packed delay bus.
    logic [CW-1:0]     delay_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_delay
            assign delay_arr[gi] = req_delay[gi*CW +: CW];
        end
    endgenerate

    // Round-robin pick: the lowest requester above the last owner wins;
    // failing that, wrap around to the lowest requester at or below it.
    // Scanning downwards lets the lowest matching index overwrite the others.
    logic              hi_found, lo_found;
    logic [IW-1:0]     hi_sel, lo_sel;
    logic              arb_found;
    logic [IW-1:0]     arb_sel;

    // Combinational round-robin arbiter over the live request vector.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IW'(i) > last_q) begin
                    hi_found = 1'b1;
                    hi_sel   = IW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_sel   = IW'(i);
                end
            end
        end
        arb_found = hi_found | lo_found;
        arb_sel   = hi_found ? hi_sel : lo_sel;
    end

    // Next-state and registered-output logic for the IDLE/COUNT/DONE service.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (arb_found) begin
                    // The delay is captured here and never looked at again,
                    // so later changes on req_delay cannot disturb the count.
                    state_d         = S_COUNT;
                    gnt_d[arb_sel]  = 1'b1;
                    count_d         = delay_arr[arb_sel];
                    last_d          = arb_sel;
                end
            end

            S_COUNT: begin
                // last_q doubles as the index of the current owner.
                if (abort || !req[last_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                end else if (count_q == '0) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end

            S_DONE: begin
                // The pulse is already on the wire; abort has nothing to cancel.
                state_d = S_IDLE;
                gnt_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign count = count_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: doc/countdown_scheduler.md
Name: countdown_scheduler

Overview:
- Shares a single CW-bit down-counter between NREQ requesters, each of which needs a timed delay.
- A round-robin arbiter grants the counter to one requester and loads that requester's delay value. The counter then counts down to zero, and the block returns a one-cycle done pulse to the owner.
- Sits between the timing clients (e.g. debounce, wait-state, timeout logic) and the shared counter datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 4, counter/delay width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req  input  NREQ  per-requester level request; held until done or withdrawn
req_delay  input  NREQ*CW  packed delay values, requester i at bits [i*CW +: CW]
abort  input  1  synchronous global cancel of the current service
gnt  output  NREQ  one-hot grant, high for the whole service (COUNT and DONE states)
done  output  NREQ  one-hot one-cycle completion pulse
busy  output  1  high whenever state != IDLE
count  output  CW  live value of the shared down-counter

Behaviour:
- All outputs are registered, except busy, which is decoded from the state register.
- Reset (reset=0, asynchronous):
  - state=IDLE, gnt=0, done=0, count=0, busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM has three states: IDLE, COUNT, DONE.
- IDLE:
  - If req != 0: select the first set req bit searching from (last+1) mod NREQ upward, with wrap.
  - At that edge: gnt<=onehot(sel), count<=req_delay[sel], last<=sel, state<=COUNT.
  - If req == 0: remain in IDLE, gnt=0.
- COUNT:
  - Priority 1: abort=1, or req[sel]=0 (withdrawn) -> state<=IDLE, gnt<=0, count<=0, no done pulse.
  - Priority 2: count==0 -> state<=DONE, done<=onehot(sel), gnt held.
  - Otherwise: count<=count-1, unsigned, CW bits.
  - count never wraps; the decrement only happens when count != 0.
- DONE:
  - done pulses high for exactly this one cycle.
  - On the next edge: done<=0, gnt<=0, state<=IDLE.
  - abort in DONE is ignored; the done pulse has already been issued.
- Latency:
  - done asserts D+1 cycles after the gnt edge, where D = latched delay. D=0 gives done 1 cycle after gnt.
  - Minimum spacing between successive grants is D+3 cycles (COUNT D+1, DONE 1, IDLE 1).
- Sampling rules:
  - req_delay is sampled only at the grant edge; later changes are ignored.
  - Requests arriving mid-service wait and are not lost while held.
- Fairness: the requester just served has the lowest priority at the next arbitration, so no requester starves while it holds req.
- Requester duties: after seeing done, a requester must drop req in the following cycle if it wants no further service. If req is still high at the next IDLE arbitration and the round-robin order selects it, it is served again.
- Mid-operation reset: an asynchronous reset at any point forces the reset values immediately; no done pulse is issued.
- Width rules:
  - The maximum delay 2^CW-1 (15 by default) gives done 2^CW cycles after gnt.
  - count equals the latched delay in the first cycle after the grant.

Test Plan:
1. Single request, basic timing: req=0001, delay0=3 -> gnt=0001 at edge T; count 3,2,1,0 on T..T+3; done=0001 at T+4 for one cycle; gnt=0 and busy=0 at T+5.
2. Zero and maximum delay: delay0=0 -> done 1 cycle after gnt. delay1=15 -> done 16 cycles after gnt, count never wraps below 0.
3. Round-robin: req=1111 held with all delays=1 -> grant order 0,1,2,3,0; each done exactly once per round; gnt always one-hot.
4. Withdraw and abort:
   - req2 drops while count=5 -> next edge state IDLE, gnt=0, no done[2].
   - abort=1 during COUNT -> same result.
   - abort=1 during DONE -> done still pulses.
5. Delay changed mid-service: req_delay0 changed from 4 to 9 after grant -> done still at gnt+5.
6. Async reset mid-count: reset low at count=6, between clock edges -> gnt, done, count, busy go to 0 immediately. After release, req=1000 is granted before req=0001 only if req0 is low; with both high, req0 is granted first.
